// File: rtl/pc_next_sequencer_if.sv
// Request/response bundle between the instruction sequencer and the PC update block.
// The slave side is the sequencer; the master side issues requests and consumes in_pc/en_pc.
interface pc_next_sequencer_if;
   localparam int unsigned ADDR_W  = 16;
   localparam int unsigned DISP_W  = 8;
   localparam int unsigned COND_W  = 4;
   localparam int unsigned FLAGS_W = 5;

   logic                 req_valid;
   logic                 req_ready;
   logic                 stall;
   logic [ADDR_W-1:0]    pc_cur;
   logic                 jmp_req;
   logic [ADDR_W-1:0]    jmp_target;
   logic                 br_req;
   logic [COND_W-1:0]    br_cond;
   logic [DISP_W-1:0]    br_disp;
   logic [FLAGS_W-1:0]   flags;
   logic [ADDR_W-1:0]    in_pc;
   logic                 en_pc;
   logic                 taken;
   logic                 done;

   modport master (
      output req_valid, stall, pc_cur, jmp_req, jmp_target, br_req, br_cond, br_disp, flags,
      input  req_ready, in_pc, en_pc, taken, done
   );

   modport slave (
      input  req_valid, stall, pc_cur, jmp_req, jmp_target, br_req, br_cond, br_disp, flags,
      output req_ready, in_pc, en_pc, taken, done
   );
endinterface

// File: rtl/pc_next_sequencer.sv
// Computes the next PC (increment / conditional branch / jump) and loads it into the
// program counter with a registered en_pc pulse framed by a setup and a hold cycle.
module pc_next_sequencer #(
   parameter logic [15:0]  STEP         = 16'd1,
   parameter int unsigned  PULSE_CYCLES = 1
) (
   input  logic               clk,
   input  logic               reset,
   pc_next_sequencer_if.slave bus
);
   localparam int unsigned ADDR_W = 16;
   localparam int unsigned DISP_W = 8;
   localparam int unsigned CNT_W  = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      PULSE = 2'd2,
      HOLD  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   in_pc_q, in_pc_d;
   logic                en_pc_q, en_pc_d;
   logic                taken_q, taken_d;
   logic                done_q, done_d;
   logic                req_ready_q, req_ready_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                flag_c, flag_l, flag_f, flag_z, flag_n;
   logic                cond_true_c;
   logic [ADDR_W-1:0]   disp_ext_c;
   logic [ADDR_W-1:0]   next_pc_c;
   logic                next_taken_c;
   logic                accept_c;
   logic                pulse_last_c;

   assign {flag_c, flag_l, flag_f, flag_z, flag_n} = bus.flags;
   assign disp_ext_c   = {{(ADDR_W-DISP_W){bus.br_disp[DISP_W-1]}}, bus.br_disp};
   assign accept_c     = (state_q == IDLE) && bus.req_valid && req_ready_q && !bus.stall;
   assign pulse_last_c = (cnt_q == CNT_W'(PULSE_CYCLES - 1));

   // Branch condition decode
   always_comb begin
      cond_true_c = 1'b0;
      case (bus.br_cond)
         4'h0: cond_true_c = flag_z;
         4'h1: cond_true_c = !flag_z;
         4'h2: cond_true_c = flag_c;
         4'h3: cond_true_c = !flag_c;
         4'h4: cond_true_c = flag_l;
         4'h5: cond_true_c = !flag_l;
         4'h6: cond_true_c = flag_n;
         4'h7: cond_true_c = !flag_n;
         4'h8: cond_true_c = flag_f;
         4'h9: cond_true_c = !flag_f;
         4'hA: cond_true_c = !flag_l && !flag_z;
         4'hB: cond_true_c = flag_l || flag_z;
         4'hC: cond_true_c = !flag_n && !flag_z;
         4'hD: cond_true_c = flag_n || flag_z;
         4'hE: cond_true_c = 1'b1;
         default: cond_true_c = 1'b0;
      endcase
   end

   // Next-address select: jump beats branch beats sequential flow
   always_comb begin
      next_pc_c    = bus.pc_cur + STEP;
      next_taken_c = 1'b0;
      if (bus.jmp_req) begin
         next_pc_c    = bus.jmp_target;
         next_taken_c = 1'b1;
      end else if (bus.br_req && cond_true_c) begin
         next_pc_c    = bus.pc_cur + disp_ext_c;
         next_taken_c = 1'b1;
      end
   end

   // State register
   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept_c) state_d = SETUP;
         SETUP:   state_d = PULSE;
         PULSE:   if (pulse_last_c) state_d = HOLD;
         HOLD:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Output logic: values the output flops take on the coming edge
   always_comb begin
      in_pc_d     = in_pc_q;
      taken_d     = taken_q;
      en_pc_d     = 1'b0;
      done_d      = 1'b0;
      req_ready_d = 1'b0;
      cnt_d       = cnt_q;
      case (state_q)
         IDLE: begin
            req_ready_d = 1'b1;
            if (accept_c) begin
               in_pc_d     = next_pc_c;
               taken_d     = next_taken_c;
               req_ready_d = 1'b0;
            end
         end
         SETUP: begin
            en_pc_d = 1'b1;
            cnt_d   = '0;
         end
         PULSE: begin
            if (!pulse_last_c) begin
               en_pc_d = 1'b1;
               cnt_d   = cnt_q + CNT_W'(1);
            end
         end
         HOLD: begin
            done_d      = 1'b1;
            req_ready_d = 1'b1;
         end
         default: begin
            req_ready_d = 1'b1;
         end
      endcase
   end

   // Output and counter registers; reset drops en_pc immediately and aborts any update
   always_ff @(posedge clk) begin
      if (!reset) begin
         in_pc_q     <= '0;
         en_pc_q     <= 1'b0;
         taken_q     <= 1'b0;
         done_q      <= 1'b0;
         req_ready_q <= 1'b1;
         cnt_q       <= '0;
      end else begin
         in_pc_q     <= in_pc_d;
         en_pc_q     <= en_pc_d;
         taken_q     <= taken_d;
         done_q      <= done_d;
         req_ready_q <= req_ready_d;
         cnt_q       <= cnt_d;
      end
   end

   assign bus.in_pc     = in_pc_q;
   assign bus.en_pc     = en_pc_q;
   assign bus.taken     = taken_q;
   assign bus.done      = done_q;
   assign bus.req_ready = req_ready_q;
endmodule

// File: tb/tb_pc_next_sequencer.sv
// Scoreboard bench for pc_next_sequencer: stimulus queues hand-computed results,
// a negedge monitor checks each en_pc pulse and done pulse against them.
module tb_pc_next_sequencer;
   logic clk   = 1'b0;
   logic reset = 1'b0;

   pc_next_sequencer_if bus ();

   pc_next_sequencer dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [15:0] pc;
      logic        tk;
      logic [31:0] acc;
   } exp_t;

   exp_t          exp_q[$];
   exp_t          done_q[$];
   exp_t          mon_e;
   exp_t          mon_d;
   int unsigned   cyc = 0;
   int            n_checks = 0;
   int            n_errors = 0;
   logic [15:0]   prev_in_pc = 16'h0;
   logic [31:0]   last_acc = 0;
   logic [31:0]   first_acc = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: every en_pc cycle and every done cycle is matched to a queued expectation
   always @(negedge clk) begin
      if (bus.en_pc === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_en_pc: got en_pc=1 in_pc=%h, required no pulse (cycle %0d)", bus.in_pc, cyc);
         end else begin
            mon_e = exp_q.pop_front();
            chk("in_pc", 32'(bus.in_pc), 32'(mon_e.pc));
            chk("taken", 32'(bus.taken), 32'(mon_e.tk));
            chk("en_cycle", 32'(cyc), mon_e.acc + 32'd1);
            chk("setup_pc", 32'(prev_in_pc), 32'(mon_e.pc));
            done_q.push_back(mon_e);
         end
      end
      if (bus.done === 1'b1) begin
         if (done_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got done=1, required no done (cycle %0d)", cyc);
         end else begin
            mon_d = done_q.pop_front();
            chk("done_cycle", 32'(cyc), mon_d.acc + 32'd3);
            chk("hold_pc", 32'(bus.in_pc), 32'(mon_d.pc));
            chk("done_ready", 32'(bus.req_ready), 32'd1);
         end
      end
      prev_in_pc = bus.in_pc;
   end

   task automatic set_in(input logic [15:0] pc, input logic jmp, input logic [15:0] tgt,
                         input logic br, input logic [3:0] cond, input logic [7:0] disp,
                         input logic [4:0] flg);
      bus.pc_cur     = pc;
      bus.jmp_req    = jmp;
      bus.jmp_target = tgt;
      bus.br_req     = br;
      bus.br_cond    = cond;
      bus.br_disp    = disp;
      bus.flags      = flg;
   endtask

   // Present a request and wait for its accepting edge; returns just after that edge
   task automatic do_req(input logic [15:0] pc, input logic jmp, input logic [15:0] tgt,
                         input logic br, input logic [3:0] cond, input logic [7:0] disp,
                         input logic [4:0] flg, input logic [15:0] exp_pc, input logic exp_tk,
                         input logic keep);
      exp_t e;
      bit   ok;
      set_in(pc, jmp, tgt, br, cond, disp, flg);
      bus.req_valid = 1'b1;
      ok = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (bus.req_ready === 1'b1 && bus.stall === 1'b0) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      if (!ok) begin
         n_checks++;
         n_errors++;
         $display("FAIL accept_timeout: got req_ready=%b, required 1 within 20 cycles", bus.req_ready);
      end
      e.pc  = exp_pc;
      e.tk  = exp_tk;
      e.acc = 32'(cyc) + 32'd1;
      last_acc = e.acc;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      if (!keep) bus.req_valid = 1'b0;
   endtask

   task automatic wait_done();
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.done === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      if (!seen) begin
         n_checks++;
         n_errors++;
         $display("FAIL done_timeout: got no done, required done within 20 cycles");
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      bus.req_valid = 1'b1;
      bus.stall     = 1'b0;
      set_in(16'h0000, 1'b0, 16'h0000, 1'b0, 4'h0, 8'h00, 5'h00);

      // Reset held two cycles with req_valid high
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("rst_en_pc", 32'(bus.en_pc), 32'd0);
         chk("rst_in_pc", 32'(bus.in_pc), 32'd0);
         chk("rst_done", 32'(bus.done), 32'd0);
         chk("rst_ready", 32'(bus.req_ready), 32'd1);
         chk("rst_taken", 32'(bus.taken), 32'd0);
      end
      bus.req_valid = 1'b0;
      @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk);
      #1;

      // Increment, branches, priority, wrap, condition samples
      do_req(16'h0010, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000, 16'h0011, 0, 0); wait_done();
      do_req(16'h0002, 0, 16'h0000, 1, 4'h0, 8'hFC, 5'b00010, 16'hFFFE, 1, 0); wait_done();
      do_req(16'h0002, 0, 16'h0000, 1, 4'h0, 8'hFC, 5'b00000, 16'h0003, 0, 0); wait_done();
      do_req(16'h0050, 1, 16'h1234, 1, 4'hE, 8'h10, 5'b00000, 16'h1234, 1, 0);
      set_in(16'hAAAA, 0, 16'h5555, 1, 4'hE, 8'h01, 5'b11111);
      wait_done();
      do_req(16'hFFFF, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000, 16'h0000, 0, 0); wait_done();
      do_req(16'h0100, 0, 16'h0000, 1, 4'h4, 8'h10, 5'b01000, 16'h0110, 1, 0); wait_done();
      do_req(16'h0100, 0, 16'h0000, 1, 4'hA, 8'h10, 5'b00010, 16'h0101, 0, 0); wait_done();
      do_req(16'h0200, 0, 16'h0000, 1, 4'hF, 8'h10, 5'b11111, 16'h0201, 0, 0); wait_done();
      do_req(16'h0200, 0, 16'h0000, 1, 4'hD, 8'h7F, 5'b00001, 16'h027F, 1, 0); wait_done();
      do_req(16'h0300, 0, 16'h0000, 1, 4'h9, 8'h10, 5'b00100, 16'h0301, 0, 0); wait_done();
      do_req(16'h0300, 0, 16'h0000, 1, 4'h3, 8'h80, 5'b00000, 16'h0280, 1, 0); wait_done();

      // Stall in IDLE blocks acceptance for three cycles
      bus.stall = 1'b1;
      set_in(16'h0400, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000);
      bus.req_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_ready", 32'(bus.req_ready), 32'd1);
         chk("stall_en_pc", 32'(bus.en_pc), 32'd0);
      end
      bus.stall = 1'b0;
      do_req(16'h0400, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000, 16'h0401, 0, 0);
      // Stall asserted during PULSE is ignored
      @(posedge clk);
      #1;
      bus.stall = 1'b1;
      wait_done();
      bus.stall = 1'b0;

      // req_valid held: second accept exactly four edges after the first
      do_req(16'h0500, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000, 16'h0501, 0, 1);
      first_acc = last_acc;
      do_req(16'h0600, 1, 16'h0ABC, 0, 4'h0, 8'h00, 5'b00000, 16'h0ABC, 1, 0);
      chk("b2b_accept_edge", last_acc, first_acc + 32'd4);
      wait_done();

      // Reset during PULSE aborts the update
      do_req(16'h0ABC, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000, 16'h0ABD, 0, 0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_en_pc", 32'(bus.en_pc), 32'd0);
      chk("abort_in_pc", 32'(bus.in_pc), 32'd0);
      chk("abort_done", 32'(bus.done), 32'd0);
      chk("abort_ready", 32'(bus.req_ready), 32'd1);
      done_q.delete();
      reset = 1'b1;
      repeat (6) @(posedge clk);
      #1;
      chk("abort_idle_ready", 32'(bus.req_ready), 32'd1);

      // Recovery after abort
      do_req(16'h0700, 0, 16'h0000, 0, 4'h0, 8'h00, 5'b00000, 16'h0701, 0, 0); wait_done();

      repeat (3) @(negedge clk);
      chk("pending_en_pc", 32'(exp_q.size()), 32'd0);
      chk("pending_done", 32'(done_q.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
